// File: rtl/pe_line_sequencer.sv
// Per-line scheduler for the priority-evaluation stage. For every pixel column
// it walks a slot of NUM_LAYERS + READ_LAT phases: one address strobe per layer,
// the matching data-capture strobe READ_LAT cycles later, and a final commit
// phase that also clears the accumulators. One scanline runs per start request.
module pe_line_sequencer #(
  parameter int unsigned NUM_LAYERS  = 2,
  parameter int unsigned READ_LAT    = 2,
  parameter int unsigned LINE_WIDTH  = 240,
  parameter int unsigned START_DELAY = 3,
  parameter int unsigned COL_W       = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  stall,
  output logic                  clear,
  output logic [COL_W-1:0]      col,
  output logic [NUM_LAYERS-1:0] send_address,
  output logic [NUM_LAYERS-1:0] read_data,
  output logic                  pixel_commit,
  output logic                  busy,
  output logic                  line_done
);

  localparam int unsigned Slot  = NUM_LAYERS + READ_LAT;
  // Slot is at least 2, so the phase counter always needs at least one bit.
  localparam int unsigned PhW   = $clog2(Slot);
  localparam int unsigned WarmW = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;

  localparam logic [PhW-1:0]   PhLast   = PhW'(Slot - 1);
  localparam logic [WarmW-1:0] WarmLast = WarmW'(START_DELAY - 1);
  localparam logic [COL_W-1:0] ColLast  = COL_W'(LINE_WIDTH - 1);

  typedef enum logic [1:0] {
    StIdle,
    StWarmup,
    StRun,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [PhW-1:0]   phase_q, phase_d;
  logic [WarmW-1:0] warm_q, warm_d;
  logic [COL_W-1:0] col_q, col_d;

  // A pixel phase only takes effect in RUN when the pipeline is not stalled.
  logic run_active;
  assign run_active = (state_q == StRun) && !stall;

  // Next-state logic: warm-up countdown, phase walk, column step and line end.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    warm_d  = warm_q;
    col_d   = col_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StWarmup;
          warm_d  = '0;
          col_d   = '0;
          phase_d = '0;
        end
      end
      StWarmup: begin
        if (warm_q == WarmLast) begin
          state_d = StRun;
          phase_d = '0;
        end else begin
          warm_d = warm_q + WarmW'(1);
        end
      end
      StRun: begin
        if (!stall) begin
          if (phase_q == PhLast) begin
            phase_d = '0;
            if (col_q == ColLast) begin
              col_d   = '0;
              state_d = StDone;
            end else begin
              col_d = col_q + COL_W'(1);
            end
          end else begin
            phase_d = phase_q + PhW'(1);
          end
        end
      end
      StDone: begin
        // start is deliberately not sampled here; the requester re-asserts.
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Sequencer state registers; reset aborts a line without a done pulse.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      phase_q <= '0;
      warm_q  <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      warm_q  <= warm_d;
      col_q   <= col_d;
    end
  end

  // Output decode from registered state; stall gates every RUN strobe.
  always_comb begin
    send_address = '0;
    read_data    = '0;
    for (int i = 0; i < int'(NUM_LAYERS); i++) begin
      send_address[i] = run_active && (phase_q == PhW'(i));
      read_data[i]    = run_active && (phase_q == PhW'(i + int'(READ_LAT)));
    end
    pixel_commit = run_active && (phase_q == PhLast);
    clear        = (state_q == StWarmup) || pixel_commit;
    busy         = (state_q == StWarmup) || (state_q == StRun);
    line_done    = (state_q == StDone);
    col          = col_q;
  end

endmodule

// File: doc/pe_line_sequencer.md
Name: pe_line_sequencer

Overview:
- Parametrised per-line scheduler for the priority-evaluation stage.
- For each pixel column it issues per-layer address strobes and data-capture strobes, with a configurable read latency.
- It also produces a commit/clear pulse and steps the column index across one scanline.
- It runs one line per start request, supports stalls, and reports completion back to the line controller.

Parameters:
NUM_LAYERS, 2, number of layer channels evaluated per pixel (>=1)
READ_LAT, 2, cycles from send_address[i] to the matching read_data[i] (>=1)
LINE_WIDTH, 240, pixels per scanline (>=2)
START_DELAY, 3, warm-up cycles with clear held high before the first pixel (>=1)
COL_W, 8, column output width; must satisfy 2**COL_W >= LINE_WIDTH

Ports:
clock  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
start  input  1  request one scanline; sampled only in IDLE
stall  input  1  freeze the pixel pipeline while high; effective in RUN only
clear  output  1  clear accumulators (warm-up and pixel commit)
col  output  COL_W  current pixel column
send_address  output  NUM_LAYERS  one-hot per-layer address strobe
read_data  output  NUM_LAYERS  one-hot per-layer data capture strobe
pixel_commit  output  1  final phase of a pixel slot
busy  output  1  high in WARMUP and RUN
line_done  output  1  single-cycle pulse after the last pixel

Behaviour:
- Derived values: SLOT = NUM_LAYERS + READ_LAT cycles per pixel; the phase counter spans 0..SLOT-1.
- Reset (reset_n low, asynchronous): state IDLE, phase 0, warm-up counter 0, col 0. All outputs are 0.
- All outputs are combinational from registered state. No output depends combinationally on start.
- States:
  - IDLE: all strobes 0, col holds its last value. start=1 -> WARMUP, loads warm counter 0 and col 0.
  - WARMUP: clear=1, busy=1. The counter increments each cycle. When count == START_DELAY-1 -> RUN with phase 0. stall is ignored in WARMUP. WARMUP lasts exactly START_DELAY cycles.
  - RUN: busy=1. While stall=1, phase and col hold and every strobe (send_address, read_data, clear, pixel_commit) is 0. While stall=0, the phase advances by 1 per cycle.
  - DONE: line_done=1 for one cycle, busy=0 -> IDLE.
- RUN strobes, with stall=0 and phase p:
  - send_address[i] = 1 when p == i, for i < NUM_LAYERS.
  - read_data[i] = 1 when p == i + READ_LAT.
  - pixel_commit = clear = 1 when p == SLOT-1.
  - send_address and read_data of the same layer never overlap. Different layers may overlap when READ_LAT < NUM_LAYERS.
- End of slot (p == SLOT-1, stall=0):
  - phase -> 0.
  - If col == LINE_WIDTH-1: col -> 0 and state -> DONE.
  - Otherwise col -> col+1.
- col is valid throughout the slot. It never exceeds LINE_WIDTH-1 and wraps only at end of line.
- Timing:
  - start high at clock edge t -> WARMUP in cycles t+1 .. t+START_DELAY.
  - First send_address[0] in cycle t+START_DELAY+1.
  - With no stalls, line_done appears START_DELAY + LINE_WIDTH*SLOT + 1 cycles after the start edge.
- start while busy or in DONE: ignored, with no effect on the current line.
- start in the same cycle DONE is presented: ignored; the requester re-asserts.
- stall asserted on the pixel_commit phase: the commit is suppressed and deferred to the first unstalled cycle.
- reset_n asserted mid-line: immediate return to IDLE and col 0. No line_done pulse.

Test Plan:
- Reset, then start pulse (defaults, SLOT=4):
  - clear=1 for exactly 3 cycles, busy=1.
  - Then per pixel: send_address 01, 10; read_data 01, 10.
  - read_data[0] falls two cycles after send_address[0]; the phase-3 cycle also carries clear=1 and pixel_commit=1.
  - col 0 -> 1 on the cycle after commit.
- Full line without stalls:
  - col reaches 239 and then wraps to 0.
  - line_done pulses exactly once at start-edge + 3 + 960 + 1 cycles; busy=0 afterwards; 240 pixel_commit pulses counted.
- stall high for 5 cycles at phase 1 of col 17:
  - col stays 17, all strobes 0 during the stall.
  - Resumes with send_address[1]; line_done delayed by exactly 5 cycles.
- stall high exactly on the commit phase:
  - No commit pulse while stalled.
  - Commit fires on the first unstalled cycle; col increments only afterwards.
- start pulses during RUN and during the DONE cycle:
  - Ignored; exactly one line_done per accepted start.
  - A new start issued in IDLE afterwards runs a full line again.
- reset_n low at col 100:
  - Outputs go to 0 and col to 0 asynchronously; no line_done.
  - Parameter sweep NUM_LAYERS=4, READ_LAT=1, LINE_WIDTH=160, COL_W=8: SLOT=5, read_data[i] one cycle after send_address[i], col wraps at 159.
